// File: rtl/fetch_addr_gen_if.sv
// rtl/fetch_addr_gen_if.sv - redirect, TLB lookup, I-cache and fetch-buffer signals of the fetch pointer sequencer
interface fetch_addr_gen_if;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        fb_space;
  logic        f_ren;
  logic [31:0] f_address;
  logic [2:0]  f_PFN;
  logic        ic_prot_exp;
  logic        ic_page_fault;
  logic        ic_req_valid;
  logic [14:0] ic_req_paddr;
  logic        ic_ready;
  logic        ic_resp_valid;
  logic        fb_wr_en;
  logic [4:0]  fb_wr_offset;
  logic        fault_valid;
  logic [1:0]  fault_code;
  logic [31:0] fault_vaddr;
  logic [31:0] perf_lines;

  // The sequencer owns requests, so it takes the master side.
  modport master (
    input  redirect_valid, redirect_addr, fb_space, f_PFN, ic_prot_exp, ic_page_fault,
           ic_ready, ic_resp_valid,
    output f_ren, f_address, ic_req_valid, ic_req_paddr, fb_wr_en, fb_wr_offset,
           fault_valid, fault_code, fault_vaddr, perf_lines
  );

  modport slave (
    output redirect_valid, redirect_addr, fb_space, f_PFN, ic_prot_exp, ic_page_fault,
           ic_ready, ic_resp_valid,
    input  f_ren, f_address, ic_req_valid, ic_req_paddr, fb_wr_en, fb_wr_offset,
           fault_valid, fault_code, fault_vaddr, perf_lines
  );
endinterface

// File: rtl/fetch_addr_gen.sv
// rtl/fetch_addr_gen.sv - fetch pointer sequencer feeding TLB lookup, I-cache and fetch buffer
// Optional line counter on perf_lines enabled by defining FETCH_PERF_CNT_EN.
module fetch_addr_gen #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned LINE_SHIFT = 5
) (
  input logic              clk,
  input logic              rst,
  fetch_addr_gen_if.master bus
);
  typedef enum logic [1:0] {FETCH, WAIT_RESP, DRAIN, FAULT} state_t;

  state_t      state;
  logic [31:0] fetch_ptr;
  logic [31:0] next_line;
  logic        f_ren;
  logic        exc;
  logic        ic_req_valid;
  logic        fb_wr_en;
  logic [4:0]  fb_wr_offset;
  logic        fault_valid;
  logic [1:0]  fault_code;
  logic [31:0] fault_vaddr;

  assign f_ren        = (state == FETCH) & bus.fb_space & ~bus.redirect_valid;
  assign exc          = bus.ic_prot_exp | bus.ic_page_fault;
  assign ic_req_valid = f_ren & ~exc;
  // Next sequential line start; the top line wraps naturally to address 0.
  assign next_line    = {fetch_ptr[31:LINE_SHIFT] + {{(31-LINE_SHIFT){1'b0}}, 1'b1},
                         {LINE_SHIFT{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      fetch_ptr    <= RESET_ADDR;
      fb_wr_en     <= 1'b0;
      fb_wr_offset <= '0;
      fault_valid  <= 1'b0;
      fault_code   <= 2'b00;
      fault_vaddr  <= '0;
    end else begin
      fb_wr_en <= 1'b0;
      if (bus.redirect_valid) begin
        fetch_ptr   <= bus.redirect_addr;
        fault_valid <= 1'b0;
        // An in-flight response must still be swallowed before fetching again.
        case (state)
          WAIT_RESP, DRAIN: state <= bus.ic_resp_valid ? FETCH : DRAIN;
          default:          state <= FETCH;
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (f_ren && exc) begin
              state       <= FAULT;
              fault_valid <= 1'b1;
              fault_vaddr <= fetch_ptr;
              fault_code  <= bus.ic_prot_exp ? 2'b01 : 2'b10;
            end else if (ic_req_valid && bus.ic_ready) begin
              state <= WAIT_RESP;
            end
          end
          WAIT_RESP: begin
            if (bus.ic_resp_valid) begin
              fb_wr_en     <= 1'b1;
              fb_wr_offset <= fetch_ptr[4:0];
              fetch_ptr    <= next_line;
              state        <= FETCH;
            end
          end
          DRAIN: begin
            if (bus.ic_resp_valid) state <= FETCH;
          end
          default: state <= FAULT;
        endcase
      end
    end
  end

  assign bus.f_ren        = f_ren;
  assign bus.f_address    = fetch_ptr;
  assign bus.ic_req_valid = ic_req_valid;
  assign bus.ic_req_paddr = {bus.f_PFN, fetch_ptr[11:0]};
  assign bus.fb_wr_en     = fb_wr_en;
  assign bus.fb_wr_offset = fb_wr_offset;
  assign bus.fault_valid  = fault_valid;
  assign bus.fault_code   = fault_code;
  assign bus.fault_vaddr  = fault_vaddr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst)           perf_cnt <= '0;
    else if (fb_wr_en) perf_cnt <= perf_cnt + 32'd1;
  end

  assign bus.perf_lines = perf_cnt;
`else
  assign bus.perf_lines = '0;
`endif
endmodule

// File: doc/fetch_addr_gen.md
Name: fetch_addr_gen

Overview:
- Fetch-pointer sequencer directly upstream of the fetch TLB lookup stage.
- Drives the linear fetch address and read enable into the TLB lookup, and consumes the returned 3-bit PFN and protection/page-fault flags.
- Issues 32-byte-line physical requests to the I-cache and writes returned lines into the fetch buffer.
- Handles redirects, stale-response draining and fault latching.

Parameters:
RESET_ADDR, 32'h0000_0000, linear fetch address loaded on reset
LINE_SHIFT, 5, log2 of the line size in bytes; fixed at 5 (32-byte lines)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
redirect_valid  in  1  load a new fetch pointer (branch/exception/start)
redirect_addr  in  32  new linear fetch address
fb_space  in  1  fetch buffer can accept one line
f_ren  out  1  TLB lookup enable (combinational)
f_address  out  32  linear fetch address, always equal to fetch_ptr
f_PFN  in  3  physical frame number from the TLB lookup
ic_prot_exp  in  1  CS limit violation for f_address
ic_page_fault  in  1  TLB miss for f_address
ic_req_valid  out  1  I-cache request valid (combinational)
ic_req_paddr  out  15  {f_PFN, f_address[11:0]}
ic_ready  in  1  I-cache accepts the request this cycle
ic_resp_valid  in  1  line data returned (one per accepted request)
fb_wr_en  out  1  one-cycle pulse: write the returned line into the fetch buffer
fb_wr_offset  out  5  start byte within the written line (fetch_ptr[4:0])
fault_valid  out  1  fetch fault latched; held until redirect
fault_code  out  2  01 = protection fault, 10 = page fault
fault_vaddr  out  32  faulting linear address
perf_lines  out  32  lines delivered; optional, see below

Behaviour:
- State machine states: FETCH, WAIT_RESP, DRAIN, FAULT.
- Reset (sync): state=FETCH, fetch_ptr=RESET_ADDR. All registered outputs reset to 0: fault_valid, fault_code, fault_vaddr, fb_wr_en, fb_wr_offset, perf_lines. f_address=RESET_ADDR.
- Combinational outputs:
  - f_ren = (state==FETCH) & fb_space & ~redirect_valid.
  - ic_req_valid = f_ren & ~ic_prot_exp & ~ic_page_fault.
- FETCH:
  - If f_ren and (ic_prot_exp | ic_page_fault): go to FAULT.
    - Set fault_valid=1 and fault_vaddr=fetch_ptr.
    - fault_code=01 if ic_prot_exp, else 10; protection has priority when both are set.
  - Else if ic_req_valid & ic_ready: go to WAIT_RESP.
  - Else stay in FETCH. The request may be withdrawn while not yet accepted.
- WAIT_RESP, on ic_resp_valid:
  - fb_wr_en=1 next cycle, with fb_wr_offset=fetch_ptr[4:0].
  - fetch_ptr = {fetch_ptr[31:5]+1, 5'b0}; 32'hFFFF_FFE0 wraps to 0.
  - Go to FETCH.
- DRAIN: waits for the one outstanding response and discards it (no fb_wr_en), then goes to FETCH.
- FAULT: no requests are issued. Leaves only on redirect.
- Redirect handling, from any state, with redirect_valid sampled each cycle:
  - fetch_ptr=redirect_addr; fault_valid cleared to 0.
  - From WAIT_RESP without a same-cycle ic_resp_valid: go to DRAIN.
  - From WAIT_RESP with a same-cycle ic_resp_valid: the response is dropped, no fb_wr_en, go to FETCH.
  - From DRAIN: stay in DRAIN with the pointer updated. If ic_resp_valid arrives in the same cycle, go to FETCH.
  - Otherwise: go to FETCH.
- Latency and throughput:
  - Accepted request to fb_wr_en is the I-cache latency plus 1 cycle.
  - At most one request is outstanding.
- Exceptions are only evaluated when f_ren=1. fb_space low in FETCH simply stalls, with no fault.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: perf_lines increments on every fb_wr_en pulse, wraps at 2^32, and is cleared by rst.
- Undefined: perf_lines is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset with RESET_ADDR=32'h0000_1004, fb_space=1, TLB hit with PFN=3'h5, ic_ready=1, response 2 cycles later. Required: f_address=0x1004, ic_req_paddr=15'h5004, fb_wr_en pulse with fb_wr_offset=4, then f_address=0x1020.
- ic_page_fault=1 during f_ren at 0x2000. Required: fault_valid=1, fault_code=10, fault_vaddr=0x2000, no ic_req_valid. Then redirect to 0x3000: fault_valid=0, fetch resumes at 0x3000.
- ic_prot_exp=1 and ic_page_fault=1 together. Required: fault_code=01.
- Redirect to 0x4000 one cycle after request acceptance. Required: the response two cycles later produces no fb_wr_en; the next request is for 0x4000.
- Redirect coincident with ic_resp_valid in WAIT_RESP. Required: no fb_wr_en, state FETCH the next cycle, no DRAIN.
- fetch_ptr=32'hFFFF_FFE0 and fb_space toggling 1/0. Required: f_ren low whenever fb_space is low; after delivery the pointer wraps to 0x0000_0000. With FETCH_PERF_CNT_EN defined, perf_lines increments once per delivered line.
